ps2_key_status: RTL and testbench

Receives the PS/2 keyboard serial stream and maintains a 26-bit held-key bitmap for letters A–Z, bit 0 = A … bit 25 = Z. It sits directly upstream of the gameplay and menu screens, which edge-detect on this bitmap. The block handles:
- synchronisation of the raw `ps2_clk`/`ps2_data` pins;
- frame reception and validation;
- make/break (`F0`) and extended (`E0`) prefix tracking;
- set-2 scan-code-to-letter mapping.

---
 rtl/ps2_key_status.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_status.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_status.sv
// PS/2 set-2 receiver that tracks the held state of letter keys A-Z as a 26-bit bitmap.
// Optional build macro: PS2_PARITY_CHECK_EN (reject frames whose data+parity weight is even).
module ps2_key_status #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [25:0] key_status,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_TERM = CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    clk_sync_r, dat_sync_r;
  logic          clk_prev_r;
  logic          fall_s, data_s, timeout_s;
  logic          shift_en_s, par_cap_s, accept_s, err_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [CW-1:0] tmo_cnt_r;
  logic [7:0]    rx_byte_r;
  logic          rx_valid_r, frame_err_r;
  logic          ext_r, brk_r;
  logic [25:0]   key_status_r;
  logic [5:0]    letter_s;

  function automatic logic odd_weight(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Set-2 make code to {hit, letter index}; hit=0 for anything that is not A-Z.
  function automatic logic [5:0] letter_lookup(input logic [7:0] code);
    logic [5:0] r;
    case (code)
      8'h1C: r = {1'b1, 5'd0};   8'h32: r = {1'b1, 5'd1};   8'h21: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};   8'h24: r = {1'b1, 5'd4};   8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};   8'h33: r = {1'b1, 5'd7};   8'h43: r = {1'b1, 5'd8};
      8'h3B: r = {1'b1, 5'd9};   8'h42: r = {1'b1, 5'd10};  8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};  8'h31: r = {1'b1, 5'd13};  8'h44: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};  8'h15: r = {1'b1, 5'd16};  8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};  8'h2C: r = {1'b1, 5'd19};  8'h3C: r = {1'b1, 5'd20};
      8'h2A: r = {1'b1, 5'd21};  8'h1D: r = {1'b1, 5'd22};  8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};  8'h1A: r = {1'b1, 5'd25};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Pin synchronisers plus the extra clock-path stage for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_data};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  assign fall_s    = clk_prev_r & ~clk_sync_r[1];
  assign data_s    = dat_sync_r[1];
  // A fall in the terminal-count cycle keeps the frame alive.
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TMO_TERM);

  // Receive FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Receive FSM next state and per-cycle actions.
  always_comb begin
    state_nxt_s = state_r;
    shift_en_s  = 1'b0;
    par_cap_s   = 1'b0;
    accept_s    = 1'b0;
    err_s       = 1'b0;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
      err_s       = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_s) begin
            state_nxt_s = ST_DATA;
          end else begin
            err_s = 1'b1;
          end
        end
        ST_DATA: begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_cap_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end
        ST_STOP: begin
          state_nxt_s = ST_IDLE;
          if (data_s && (odd_weight(shift_r, parity_r) || !PARITY_CHECK)) begin
            accept_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame datapath: shifter, bit counter, saturating inter-edge timeout counter, output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      parity_r    <= 1'b0;
      tmo_cnt_r   <= '0;
      rx_byte_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shift_r   <= {data_s, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else if (state_r == ST_IDLE) begin
        bit_cnt_r <= 3'd0;
      end
      if (par_cap_s) begin
        parity_r <= data_s;
      end
      if ((state_r == ST_IDLE) || fall_s) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != {CW{1'b1}}) begin
        tmo_cnt_r <= tmo_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        rx_byte_r <= shift_r;
      end
      rx_valid_r  <= accept_s;
      frame_err_r <= err_s;
    end
  end

  assign letter_s = letter_lookup(rx_byte_r);

  // Prefix tracking and key bitmap update, one cycle behind rx_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      key_status_r <= 26'd0;
    end else if (rx_valid_r) begin
      case (rx_byte_r)
        8'hE0: ext_r <= 1'b1;
        8'hF0: brk_r <= 1'b1;
        default: begin
          if (!ext_r && letter_s[5]) begin
            key_status_r[letter_s[4:0]] <= ~brk_r;
          end
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      endcase
    end
  end

  assign key_status = key_status_r;
  assign rx_byte    = rx_byte_r;
  assign rx_valid   = rx_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_status.sv
// Self-checking bench for ps2_key_status: table of frames with expected bitmaps,
// a received-byte scoreboard, and hand sequences for latency, parity, timeout and reset.
module tb_ps2_key_status;

  localparam int T = 50;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [25:0] key_status;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  code;
    logic [25:0] key;
  } vec_t;
  vec_t tbl [0:26];

  logic [7:0] letters [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  always #5 clk = ~clk;

  ps2_key_status #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_status (key_status),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid && frame_err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_overlap: got rx_valid=1 frame_err=1 expected not both");
    end
    if (rx_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rx: got %h expected no byte", rx_byte);
      end else begin
        chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
    if (frame_err) fe_cnt++;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_bits(input logic [7:0] d, input logic flip, output logic [10:0] fb);
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    fb[9]  = (~^d) ^ flip;
    fb[10] = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic push);
    logic [10:0] fb;
    frame_bits(d, flip, fb);
    if (push) exp_q.push_back(d);
    for (int i = 0; i < 11; i++) send_bit(fb[i]);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int fe0;
    int rv0;
    logic [10:0] fb;

    tbl[0]  = '{8'h1C, 26'h0400001};  tbl[1]  = '{8'hF0, 26'h0400001};
    tbl[2]  = '{8'h1D, 26'h0000001};  tbl[3]  = '{8'hF0, 26'h0000001};
    tbl[4]  = '{8'h1C, 26'h0000000};  tbl[5]  = '{8'hE0, 26'h0000000};
    tbl[6]  = '{8'h1C, 26'h0000000};  tbl[7]  = '{8'hE0, 26'h0000000};
    tbl[8]  = '{8'hF0, 26'h0000000};  tbl[9]  = '{8'h1C, 26'h0000000};
    tbl[10] = '{8'h1C, 26'h0000001};  tbl[11] = '{8'hF0, 26'h0000001};
    tbl[12] = '{8'hE0, 26'h0000001};  tbl[13] = '{8'h1C, 26'h0000001};
    tbl[14] = '{8'hAA, 26'h0000001};  tbl[15] = '{8'h1C, 26'h0000001};
    tbl[16] = '{8'hF0, 26'h0000001};  tbl[17] = '{8'h1B, 26'h0000001};
    tbl[18] = '{8'h1A, 26'h2000001};  tbl[19] = '{8'h15, 26'h2010001};
    tbl[20] = '{8'hFA, 26'h2010001};  tbl[21] = '{8'hF0, 26'h2010001};
    tbl[22] = '{8'h1A, 26'h0010001};  tbl[23] = '{8'hF0, 26'h0010001};
    tbl[24] = '{8'h15, 26'h0000001};  tbl[25] = '{8'hF0, 26'h0000001};
    tbl[26] = '{8'h1C, 26'h0000000};

    repeat (3) @(negedge clk);
    chk("reset_key", {6'd0, key_status}, 32'd0);
    chk("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // First frame: rx_valid then key_status exactly one cycle later.
    fork
      send_frame(8'h1D, 1'b0, 1'b1);
      begin
        w = 0;
        while (!rx_valid && w < 400) begin
          @(negedge clk);
          w++;
        end
        if (w >= 400) begin
          n_cmp++;
          n_bad++;
          $display("FAIL first_rx_wait: got no rx_valid expected pulse");
        end else begin
          chk("lat_key_old", {6'd0, key_status}, 32'd0);
          @(negedge clk);
          chk("lat_key_new", {6'd0, key_status}, 32'h0400000);
          chk("lat_rx_valid_pulse", {31'd0, rx_valid}, 32'd0);
        end
      end
    join

    fe0 = fe_cnt;
    for (int i = 0; i < 27; i++) begin
      send_frame(tbl[i].code, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_key", i), {6'd0, key_status}, {6'd0, tbl[i].key});
    end
    chk("tbl_no_frame_err", fe_cnt, fe0);

    for (int i = 0; i < 26; i++) begin
      send_frame(letters[i], 1'b0, 1'b1);
      chk($sformatf("make_%0d", i), {6'd0, key_status}, 32'd1 << i);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(letters[i], 1'b0, 1'b1);
      chk($sformatf("break_%0d", i), {6'd0, key_status}, 32'd0);
    end

    fe0 = fe_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1D, 1'b1, 1'b0);
    chk("parity_err_count", fe_cnt, fe0 + 1);
    chk("parity_key", {6'd0, key_status}, 32'd0);
`else
    send_frame(8'h1D, 1'b1, 1'b1);
    chk("parity_ignored_err", fe_cnt, fe0);
    chk("parity_ignored_key", {6'd0, key_status}, 32'h0400000);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("parity_release", {6'd0, key_status}, 32'd0);
`endif

    // Timeout: start bit plus four data bits, then the PS/2 clock stops.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    w = 0;
    while (!frame_err && w < 200) begin
      @(negedge clk);
      w++;
      if (w == H) ps2_clk = 1'b1;
    end
    ps2_clk = 1'b1;
    n_cmp++;
    if (w < T || w > T + 6) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d expected %0d..%0d", w, T, T + 6);
    end
    repeat (5) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b1);
    chk("after_timeout_S", {6'd0, key_status}, 32'h0040000);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b1);
    chk("release_S", {6'd0, key_status}, 32'd0);

    // Reset in the middle of a frame that follows a held key.
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("pre_reset_key", {6'd0, key_status}, 32'd1);
    frame_bits(8'h1C, 1'b0, fb);
    for (int i = 0; i < 5; i++) send_bit(fb[i]);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_key", {6'd0, key_status}, 32'd0);
    chk("reset_mid_rx_byte", {24'd0, rx_byte}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    for (int i = 5; i < 11; i++) send_bit(fb[i]);
    repeat (T + 20) @(negedge clk);
    chk("tail_key", {6'd0, key_status}, 32'd0);
    chk("tail_no_rx", rv_cnt, rv0);
    chk("tail_err_count", fe_cnt, fe0 + 2);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("resync_key", {6'd0, key_status}, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
